// File: rtl/multicycle_ctrl.sv
// Five-state multicycle sequencer for the MIPS datapath: decodes op/func and
// issues PC, IR, register-file and data-memory strobes one phase at a time.
module multicycle_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  op,
   input  logic [5:0]  func,
   input  logic        beq_eq,
   input  logic        rt_zero,
   input  logic        halt,
   input  logic        dmem_ack,
   output logic        ir_we,
   output logic        pc_we,
   output logic [1:0]  pc_sel,
   output logic        reg_we,
   output logic        wb_sel,
   output logic        dst_sel,
   output logic        dmem_req,
   output logic        dmem_wr,
   output logic        retire,
   output logic        illegal,
   output logic [2:0]  state,
   output logic [31:0] instret
);

   localparam logic [5:0] OP_RTYPE  = 6'b000000;
   localparam logic [5:0] OP_LW     = 6'b100011;
   localparam logic [5:0] OP_SW     = 6'b101011;
   localparam logic [5:0] OP_BEQ    = 6'b000100;
   localparam logic [5:0] OP_J      = 6'b000010;
   localparam logic [5:0] FUNC_MOVZ = 6'b001010;

   localparam logic [1:0] PC_SEQ    = 2'd0;
   localparam logic [1:0] PC_BRANCH = 2'd1;
   localparam logic [1:0] PC_JUMP   = 2'd2;

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4
   } state_t;

   state_t      state_reg;
   state_t      state_next;
   logic [31:0] instret_reg;

   logic is_rtype, is_movz, is_lw, is_sw, is_beq, is_j;

   assign is_rtype = (op == OP_RTYPE);
   assign is_movz  = is_rtype && (func == FUNC_MOVZ);
   assign is_lw    = (op == OP_LW);
   assign is_sw    = (op == OP_SW);
   assign is_beq   = (op == OP_BEQ);
   assign is_j     = (op == OP_J);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= FETCH;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      pc_sel     = PC_SEQ;
      reg_we     = 1'b0;
      wb_sel     = 1'b0;
      dst_sel    = 1'b0;
      dmem_req   = 1'b0;
      dmem_wr    = 1'b0;
      retire     = 1'b0;
      illegal    = 1'b0;

      case (state_reg)
         FETCH: begin
            if (!halt) begin
               ir_we      = 1'b1;
               state_next = DECODE;
            end
         end

         DECODE: state_next = EXEC;

         EXEC: begin
            if (is_rtype) begin
               state_next = WB;
            end else if (is_lw || is_sw) begin
               state_next = MEM;
            end else if (is_beq) begin
               pc_we      = 1'b1;
               pc_sel     = beq_eq ? PC_BRANCH : PC_SEQ;
               retire     = 1'b1;
               state_next = FETCH;
            end else if (is_j) begin
               pc_we      = 1'b1;
               pc_sel     = PC_JUMP;
               retire     = 1'b1;
               state_next = FETCH;
            end else begin
               // Unsupported opcode retires as a NOP so the PC keeps moving.
               pc_we      = 1'b1;
               illegal    = 1'b1;
               retire     = 1'b1;
               state_next = FETCH;
            end
         end

         MEM: begin
            dmem_req = 1'b1;
            dmem_wr  = is_sw;
            if (dmem_ack) begin
               if (is_sw) begin
                  pc_we      = 1'b1;
                  retire     = 1'b1;
                  state_next = FETCH;
               end else begin
                  state_next = WB;
               end
            end
         end

         WB: begin
            reg_we     = is_lw || (is_rtype && !is_movz) || (is_movz && rt_zero);
            wb_sel     = is_lw;
            dst_sel    = is_rtype;
            pc_we      = 1'b1;
            retire     = 1'b1;
            state_next = FETCH;
         end

         default: state_next = FETCH;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instret_reg <= 32'd0;
      end else if (retire) begin
         instret_reg <= instret_reg + 32'd1;
      end
   end

   assign state   = state_reg;
   assign instret = instret_reg;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized scoreboard bench for multicycle_ctrl: the driver pushes the
// expected per-instruction response, the monitor pops it on each retire.
module tb_multicycle_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [5:0]  op = 6'd0;
   logic [5:0]  func = 6'd0;
   logic        beq_eq = 1'b0;
   logic        rt_zero = 1'b0;
   logic        halt = 1'b1;
   logic        dmem_ack = 1'b0;
   logic        ir_we, pc_we, reg_we, wb_sel, dst_sel;
   logic        dmem_req, dmem_wr, retire, illegal;
   logic [1:0]  pc_sel;
   logic [2:0]  state;
   logic [31:0] instret;

   multicycle_ctrl dut (
      .clk(clk), .rst(rst), .op(op), .func(func), .beq_eq(beq_eq),
      .rt_zero(rt_zero), .halt(halt), .dmem_ack(dmem_ack), .ir_we(ir_we),
      .pc_we(pc_we), .pc_sel(pc_sel), .reg_we(reg_we), .wb_sel(wb_sel),
      .dst_sel(dst_sel), .dmem_req(dmem_req), .dmem_wr(dmem_wr),
      .retire(retire), .illegal(illegal), .state(state), .instret(instret)
   );

   always #5 clk = ~clk;

   typedef struct {
      int       cycles;
      bit       reg_we;
      bit       has_wb;
      bit       wb_sel;
      bit       dst_sel;
      bit [1:0] pc_sel;
      bit       illegal;
      int       mem_cycles;
      bit       dmem_wr;
   } exp_t;

   exp_t sb_q[$];
   int   total = 0;
   int   bad = 0;
   int   retired = 0;
   bit   mon_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   task automatic finish_run();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   endtask

   function automatic bit is_legal(input logic [5:0] o);
      return (o == 6'h00) || (o == 6'h23) || (o == 6'h2b) || (o == 6'h04) || (o == 6'h02);
   endfunction

   // Reference behaviour of one instruction, straight from the ISA rules.
   function automatic exp_t model(input logic [5:0] o, input logic [5:0] f,
                                  input bit eq, input bit rz, input int w);
      exp_t e;
      e = '{default: 0};
      case (o)
         6'h00: begin
            e.cycles  = 4;
            e.has_wb  = 1;
            e.dst_sel = 1;
            e.reg_we  = (f == 6'h0a) ? rz : 1'b1;
         end
         6'h23: begin
            e.cycles     = 5 + w;
            e.has_wb     = 1;
            e.wb_sel     = 1;
            e.reg_we     = 1;
            e.mem_cycles = w + 1;
         end
         6'h2b: begin
            e.cycles     = 4 + w;
            e.mem_cycles = w + 1;
            e.dmem_wr    = 1;
         end
         6'h04: begin
            e.cycles = 3;
            e.pc_sel = eq ? 2'd1 : 2'd0;
         end
         6'h02: begin
            e.cycles = 3;
            e.pc_sel = 2'd2;
         end
         default: begin
            e.cycles  = 3;
            e.illegal = 1;
         end
      endcase
      return e;
   endfunction

   // Called at posedge+1 of a FETCH cycle; returns at posedge+1 of the next FETCH.
   task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input bit eq,
                            input bit rz, input int w, input int h);
      int memcnt;
      int cyc;
      bit done;
      memcnt = 0;
      cyc = 0;
      done = 1'b0;
      for (int i = 0; i < h; i++) begin
         halt = 1'b1;
         op = 6'($urandom);
         @(posedge clk);
         #1;
      end
      halt = 1'b0;
      op = o;
      func = f;
      beq_eq = eq;
      rt_zero = rz;
      sb_q.push_back(model(o, f, eq, rz, w));
      while (!done) begin
         if (dmem_req) begin
            dmem_ack = (memcnt == w);
            memcnt++;
         end else begin
            dmem_ack = 1'($urandom);
         end
         #1;
         done = retire;
         cyc++;
         if (cyc > 100) begin
            total++;
            bad++;
            $display("FAIL timeout: op=%0h got no retire within %0d cycles", o, cyc);
            finish_run();
         end
         @(posedge clk);
         #1;
      end
      dmem_ack = 1'b0;
   endtask

   // Monitor: accumulates observations per instruction, compares on retire.
   initial begin : monitor
      bit   inflt;
      int   cnt, memc, pcw, early_rw;
      bit   wr_seen;
      exp_t e;
      inflt = 0; cnt = 0; memc = 0; pcw = 0; early_rw = 0; wr_seen = 0;
      forever begin
         @(negedge clk);
         if (mon_en && !rst) begin
            if (halt && state == 3'd0) begin
               check("halt_hold_state", {29'd0, state}, 32'd0);
               check("halt_strobes", {26'd0, ir_we, pc_we, reg_we, dmem_req, retire, illegal}, 32'd0);
            end
            if (ir_we) begin
               check("ir_we_while_busy", {31'd0, inflt}, 32'd0);
               inflt = 1; cnt = 0; memc = 0; pcw = 0; early_rw = 0; wr_seen = 0;
            end
            if (inflt) begin
               cnt++;
               if (dmem_req) begin
                  memc++;
                  wr_seen = dmem_wr;
               end
               if (pc_we) pcw++;
               if (retire) begin
                  if (sb_q.size() == 0) begin
                     check("unexpected_retire", 32'd1, 32'd0);
                  end else begin
                     e = sb_q.pop_front();
                     check("cycles", cnt, e.cycles);
                     check("pc_we_count", pcw, 1);
                     check("pc_sel", {30'd0, pc_sel}, {30'd0, e.pc_sel});
                     check("reg_we", {31'd0, reg_we}, {31'd0, e.reg_we});
                     check("reg_we_early", early_rw, 0);
                     check("illegal", {31'd0, illegal}, {31'd0, e.illegal});
                     check("mem_cycles", memc, e.mem_cycles);
                     if (e.mem_cycles > 0) check("dmem_wr", {31'd0, wr_seen}, {31'd0, e.dmem_wr});
                     if (e.has_wb) begin
                        check("wb_sel", {31'd0, wb_sel}, {31'd0, e.wb_sel});
                        check("dst_sel", {31'd0, dst_sel}, {31'd0, e.dst_sel});
                     end
                     check("instret", instret, retired);
                  end
                  retired++;
                  inflt = 0;
               end else begin
                  if (reg_we) early_rw++;
                  if (illegal) check("illegal_not_retire", 32'd1, 32'd0);
               end
            end
         end
      end
   end

   initial begin : driver
      logic [5:0] o, f;
      int k;
      // Reset asserted mid-cycle: everything idle immediately.
      #12;
      check("rst_state", {29'd0, state}, 32'd0);
      check("rst_instret", instret, 32'd0);
      check("rst_strobes", {26'd0, ir_we, pc_we, reg_we, dmem_req, retire, illegal}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      halt = 1'b0;
      #1;
      check("first_ir_we", {31'd0, ir_we}, 32'd1);
      halt = 1'b1;
      @(posedge clk);
      #1;
      check("halt_after_rst", {29'd0, state}, 32'd0);
      mon_en = 1'b1;

      run_instr(6'h00, 6'h20, 0, 0, 0, 0);   // ADD
      run_instr(6'h23, 6'h00, 0, 0, 3, 0);   // LW, 3 wait cycles
      run_instr(6'h2b, 6'h00, 0, 0, 0, 0);   // SW, immediate ack
      run_instr(6'h04, 6'h00, 1, 0, 0, 0);   // BEQ taken
      run_instr(6'h04, 6'h00, 0, 0, 0, 0);   // BEQ not taken
      run_instr(6'h02, 6'h00, 0, 0, 0, 0);   // J
      run_instr(6'h00, 6'h0a, 0, 0, 0, 0);   // MOVZ, condition fails
      run_instr(6'h00, 6'h0a, 0, 1, 0, 2);   // MOVZ, condition holds, after halt
      run_instr(6'h3f, 6'h00, 0, 0, 0, 3);   // illegal opcode

      for (int n = 0; n < 60; n++) begin
         k = $urandom_range(0, 6);
         f = 6'($urandom);
         case (k)
            0: o = 6'h00;
            1: begin o = 6'h00; f = 6'h0a; end
            2: o = 6'h23;
            3: o = 6'h2b;
            4: o = 6'h04;
            5: o = 6'h02;
            default: begin
               o = 6'($urandom);
               while (is_legal(o)) o = 6'($urandom);
            end
         endcase
         run_instr(o, f, 1'($urandom), 1'($urandom), $urandom_range(0, 4),
                   ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
      end

      halt = 1'b1;
      @(posedge clk);
      #1;
      check("sb_empty", sb_q.size(), 32'd0);
      check("final_instret", instret, retired);

      // Reset during MEM drops the request at once, pending ack ignored.
      mon_en = 1'b0;
      halt = 1'b0;
      op = 6'h23;
      dmem_ack = 1'b0;
      for (int i = 0; i < 10 && !dmem_req; i++) begin
         @(posedge clk);
         #1;
      end
      check("mid_mem_reached", {31'd0, dmem_req}, 32'd1);
      #2;
      halt = 1'b1;
      dmem_ack = 1'b1;
      rst = 1'b1;
      #1;
      check("mem_rst_req", {31'd0, dmem_req}, 32'd0);
      check("mem_rst_state", {29'd0, state}, 32'd0);
      check("mem_rst_instret", instret, 32'd0);
      check("mem_rst_strobes", {26'd0, ir_we, pc_we, reg_we, dmem_req, retire, illegal}, 32'd0);
      #1;
      rst = 1'b0;
      dmem_ack = 1'b0;
      halt = 1'b0;
      #1;
      check("mem_rst_ir_we", {31'd0, ir_we}, 32'd1);
      finish_run();
   end

endmodule
